// File: rtl/rom_apb_bridge.sv
// APB3 slave in front of the 2048x32 ROM macro: one wait state per access,
// registered macro strobes, write-protect and empty-write short responses.
module rom_apb_bridge #(
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [31:0]           paddr,
    input  logic                  pwrite,
    input  logic [3:0]            pstrb,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic                  rom_wp,
    output logic                  mem_cs,
    output logic [ADDR_WIDTH-3:0] mem_a,
    output logic                  mem_we,
    output logic [3:0]            mem_byte,
    output logic [31:0]           mem_di,
    input  logic [31:0]           mem_do
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   err;
    logic   rd;

    // Only the word-address bits are decoded.
    logic unused_paddr;
    assign unused_paddr = ^{paddr[31:ADDR_WIDTH], paddr[1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            err      <= 1'b0;
            rd       <= 1'b0;
            mem_cs   <= 1'b0;
            mem_a    <= '0;
            mem_we   <= 1'b0;
            mem_byte <= '0;
            mem_di   <= '0;
        end else begin
            // Strobes are single-cycle pulses; mem_a and mem_di hold.
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_byte <= '0;
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        rd <= !pwrite;
                        if (pwrite && rom_wp) begin
                            err   <= 1'b1;
                            state <= RESP;
                        end else if (pwrite && (pstrb == 4'b0000)) begin
                            err   <= 1'b0;
                            state <= RESP;
                        end else begin
                            err      <= 1'b0;
                            state    <= MEM;
                            mem_cs   <= 1'b1;
                            mem_a    <= paddr[ADDR_WIDTH-1:2];
                            mem_we   <= pwrite;
                            mem_byte <= pwrite ? pstrb : 4'b0000;
                            mem_di   <= pwdata;
                        end
                    end
                end
                MEM:     state <= psel ? RESP : IDLE;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Response gated by the live APB handshake so an aborted transfer never sees pready.
    assign pready  = (state == RESP) && psel && penable;
    assign pslverr = pready && err;
    assign prdata  = (pready && rd) ? mem_do : '0;

endmodule

// File: tb/tb_rom_apb_bridge.sv
// Self-checking bench for rom_apb_bridge with a ROM macro model and an
// independent word-array reference of the memory contents.
module tb_rom_apb_bridge;

    logic        clk;
    logic        rstn;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        rom_wp;
    logic        mem_cs;
    logic [10:0] mem_a;
    logic        mem_we;
    logic [3:0]  mem_byte;
    logic [31:0] mem_di;
    logic [31:0] mem_do;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rom     [0:2047];
    logic [31:0] ref_mem [0:2047];

    rom_apb_bridge #(.ADDR_WIDTH(13)) dut (
        .clk(clk), .rstn(rstn), .psel(psel), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .rom_wp(rom_wp),
        .mem_cs(mem_cs), .mem_a(mem_a), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_di(mem_di), .mem_do(mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM macro: byte-masked write, registered read data one cycle after cs.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_byte[b]) rom[mem_a][b*8 +: 8] <= mem_di[b*8 +: 8];
            mem_do <= rom[mem_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    // One APB transfer; wp is the setup-cycle value, wp_mid is driven afterwards.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic wp, input logic wp_mid);
        logic [10:0] wa;
        logic        access;
        logic        exp_err;
        logic [31:0] exp_rd;
        wa      = addr[12:2];
        access  = !(wr && (wp || strb == 4'b0000));
        exp_err = wr && wp;
        exp_rd  = wr ? 32'h0 : ref_mem[wa];

        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
        pstrb = strb; pwdata = wdata; rom_wp = wp;
        #1;
        chk("setup_pready", {31'b0, pready}, 32'h0);
        chk("setup_cs", {31'b0, mem_cs}, 32'h0);

        @(negedge clk);
        penable = 1'b1;
        rom_wp  = wp_mid;
        #1;
        if (access) begin
            chk("mem_cs", {31'b0, mem_cs}, 32'h1);
            chk("mem_a", {21'b0, mem_a}, {21'b0, wa});
            chk("mem_we", {31'b0, mem_we}, {31'b0, wr});
            chk("mem_byte", {28'b0, mem_byte}, wr ? {28'b0, strb} : 32'h0);
            if (wr) chk("mem_di", mem_di, wdata);
            chk("wait_pready", {31'b0, pready}, 32'h0);
            @(negedge clk);
            #1;
        end
        chk("resp_cs", {31'b0, mem_cs}, 32'h0);
        chk("resp_pready", {31'b0, pready}, 32'h1);
        chk("resp_pslverr", {31'b0, pslverr}, {31'b0, exp_err});
        chk("resp_prdata", prdata, exp_rd);

        if (access && wr)
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[wa][b*8 +: 8] = wdata[b*8 +: 8];
    endtask

    initial begin
        logic [31:0] tmp;
        rstn = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
        pstrb = '0; pwdata = '0; rom_wp = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            tmp = $urandom;
            rom[i] = tmp;
            ref_mem[i] = tmp;
        end
        rom[11'h005] = 32'hDEADBEEF; ref_mem[11'h005] = 32'hDEADBEEF;
        rom[11'h7FF] = 32'hAABBCCDD; ref_mem[11'h7FF] = 32'hAABBCCDD;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pready", {31'b0, pready}, 32'h0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
        chk("rst_cs", {31'b0, mem_cs}, 32'h0);
        chk("rst_a", {21'b0, mem_a}, 32'h0);
        chk("rst_we", {31'b0, mem_we}, 32'h0);
        chk("rst_byte", {28'b0, mem_byte}, 32'h0);
        chk("rst_di", mem_di, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        idle(1);

        // Directed: read, byte write + readback, write protect, empty write.
        xfer(1'b0, 32'h0000_0014, 4'b0000, 32'h0, 1'b0, 1'b0);
        idle(1);
        xfer(1'b1, 32'h0000_1FFC, 4'b0101, 32'h11223344, 1'b0, 1'b0);
        idle(1);
        chk("macro_7ff", rom[11'h7FF], 32'hAA22CC44);
        xfer(1'b0, 32'h0000_1FFC, 4'b0000, 32'h0, 1'b0, 1'b0);
        tmp = ref_mem[0];
        xfer(1'b1, 32'h0000_0000, 4'b1111, 32'h0, 1'b1, 1'b1);
        idle(1);
        chk("wp_word0", rom[0], tmp);
        xfer(1'b1, 32'h0000_0008, 4'b0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        xfer(1'b1, 32'h0000_0010, 4'b1111, 32'h5A5A_A5A5, 1'b0, 1'b1);
        idle(1);

        // Back-to-back, unaligned address hitting word 1.
        xfer(1'b0, 32'h0000_0000, 4'b0000, 32'h0, 1'b0, 1'b0);
        xfer(1'b1, 32'h0000_0004, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0);
        xfer(1'b0, 32'h0000_0006, 4'b0000, 32'h0, 1'b0, 1'b0);
        idle(1);

        // Asynchronous reset during the MEM cycle of a read.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = 32'h14; pwrite = 1'b0; pstrb = '0; rom_wp = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        chk("rstmid_cs_before", {31'b0, mem_cs}, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rstmid_cs", {31'b0, mem_cs}, 32'h0);
        chk("rstmid_a", {21'b0, mem_a}, 32'h0);
        chk("rstmid_pready", {31'b0, pready}, 32'h0);
        chk("rstmid_prdata", prdata, 32'h0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        xfer(1'b0, 32'h0000_0014, 4'b0000, 32'h0, 1'b0, 1'b0);
        idle(1);

        // Abort: psel dropped in the MEM cycle, next transfer immediately after.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = 32'h1FFC; pwrite = 1'b0;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        #1;
        chk("abort_cs", {31'b0, mem_cs}, 32'h1);
        chk("abort_pready", {31'b0, pready}, 32'h0);
        xfer(1'b0, 32'h0000_0004, 4'b0000, 32'h0, 1'b0, 1'b0);

        // Randomized traffic against the reference word array.
        for (int n = 0; n < 80; n++) begin
            logic        wr;
            logic [31:0] addr;
            logic [3:0]  strb;
            logic        wp;
            wr   = 1'($urandom_range(1));
            addr = 32'($urandom_range(8191));
            if (n % 3 == 0) addr = {19'b0, 2'b11, 11'b0} | (addr & 32'h1F);
            strb = 4'($urandom_range(15));
            wp   = ($urandom_range(3) == 0);
            xfer(wr, addr, strb, $urandom, wp, 1'($urandom_range(1)));
            if ($urandom_range(1) == 1) idle(1);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_apb_bridge.md
# rom_apb_bridge

APB3 slave that fronts the 2048×32 boot/data ROM macro and turns APB transfers into single-cycle macro strobes (chip select, word address, write enable, byte mask, write data). It sits between the peripheral APB decoder and the ROM macro. It registers all macro strobes for timing, returns the macro's registered read data, and enforces a write-protect input.

## Interface
Parameters:
- ADDR_WIDTH, 13: byte-address bits decoded. Word address is paddr[ADDR_WIDTH-1:2], 11 bits at the default.

Ports:
- clk  in  1  clock; rising edge; same clock as the ROM macro's CK
- rstn  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- paddr  in  32  APB byte address; only [ADDR_WIDTH-1:2] used
- pwrite  in  1  1 = write
- pstrb  in  4  write byte strobes
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error
- rom_wp  in  1  write protect; 1 = writes rejected
- mem_cs  out  1  macro chip select (registered)
- mem_a  out  11  macro word address (registered)
- mem_we  out  1  macro write enable (registered)
- mem_byte  out  4  macro byte mask (registered)
- mem_di  out  32  macro write data (registered)
- mem_do  in  32  macro read data; valid the cycle after mem_cs=1

## Operation
- FSM states: IDLE, MEM, RESP.
- IDLE: on psel=1 and penable=0 (setup phase), latch the request.
  - Write with rom_wp=1: go to RESP with err=1. Macro strobes stay 0.
  - Write with pstrb=0: go to RESP with err=0. No macro access.
  - Otherwise: go to MEM. On that edge load mem_cs=1, mem_a=paddr[12:2], mem_we=pwrite, mem_byte=(pwrite ? pstrb : 4'b0), mem_di=pwdata.
- MEM: one cycle, strobes asserted. Next state is RESP, and mem_cs/mem_we/mem_byte return to 0. mem_a and mem_di hold their values.
- RESP: pready=1 and pslverr=err.
  - For reads, prdata=mem_do, passed combinationally. prdata is 0 in every other cycle and state.
  - Next state is IDLE. A new setup phase in the cycle after RESP is accepted normally, so back-to-back transfers work.
- Abort: if psel=0 while in MEM or RESP (protocol violation), go to IDLE at the next edge. Strobes deassert. No response is issued.
- rom_wp is sampled only in the setup cycle. Changes mid-transfer do not affect the transfer in flight.
- paddr[1:0] is ignored. Unaligned accesses hit the containing word.

## Timing
- Reset values: state=IDLE, prdata=0, pready=0, pslverr=0, mem_cs=0, mem_a=0, mem_we=0, mem_byte=0, mem_di=0.
- Asynchronous reset mid-transfer forces the reset values immediately. A pending write may or may not have reached the macro, depending on whether the MEM edge occurred.
- Normal read or write: setup T0, access T1 (MEM, pready=0), T2 (RESP, pready=1). This is one wait state and a 3-cycle transfer.
- Rejected or empty write: setup T0, T1 is RESP with pready=1. This is a 2-cycle transfer with zero wait states.
- mem_cs is high for exactly one cycle per accepted transfer. It is never high in IDLE or RESP.
- pready is never asserted without psel=1 and penable=1.

## Test plan
- Read: preload word 0x005 = 0xDEADBEEF; APB read paddr=0x0000_0014. Required: mem_cs=1 with mem_a=0x005 and mem_we=0 for one cycle; in T2 pready=1, prdata=0xDEADBEEF, pslverr=0.
- Byte write then read: rom_wp=0, write paddr=0x1FFC, pstrb=4'b0101, pwdata=0x11223344 over old 0xAABBCCDD. Required: mem_byte=4'b0101 and mem_a=0x7FF. A subsequent read of 0x1FFC returns 0xAA22CC44.
- Write protect: rom_wp=1, write paddr=0x0000, pwdata=0x0. Required: pready=1 and pslverr=1 in T1, mem_cs never asserted, word 0 unchanged.
- Back-to-back: read 0x0, write 0x4, read 0x4 with no idle cycles between them. Required: each completes in 3 cycles and the third read returns the written data.
- Reset mid-transfer: assert rstn=0 in the MEM cycle of a read. Required: all outputs return to 0 asynchronously. After release, a fresh read completes normally.
- Abort: drop psel in the MEM cycle. Required: no pready, FSM returns to IDLE, and the next transfer completes normally.
